// File: rtl/pcie_tlp_req_gen.sv
// PCIe memory-request TLP header generator.
// Splits a byte-addressed read/write request into 4DW memory-request headers
// that respect max payload / max read request size and never cross a 4 KB
// page. Reads draw tags from a free bitmap that the completion path refills.
module pcie_tlp_req_gen #(
    parameter int          ADDR_WIDTH        = 64,
    parameter int          REQ_LEN_WIDTH     = 16,
    parameter int          MAX_PAYLOAD_SIZE  = 128,
    parameter int          MAX_READ_REQ_SIZE = 512,
    parameter int          TAG_WIDTH         = 8,
    parameter int          NUM_TAGS          = 32,
    parameter logic [15:0] REQUESTER_ID      = 16'h0200
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_is_write,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [REQ_LEN_WIDTH-1:0] req_len,
    output logic                     hdr_valid,
    input  logic                     hdr_ready,
    output logic [127:0]             hdr,
    output logic [12:0]              hdr_len_bytes,
    output logic                     hdr_last,
    input  logic                     tag_free_valid,
    input  logic [TAG_WIDTH-1:0]     tag_free,
    output logic                     err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EMIT     = 2'd1,
        S_WAIT_TAG = 2'd2
    } state_t;

    localparam logic [12:0] LP_MPS  = 13'(MAX_PAYLOAD_SIZE);
    localparam logic [12:0] LP_MRRS = 13'(MAX_READ_REQ_SIZE);

    state_t                   r_state, w_state_nxt;
    logic                     r_req_ready;
    logic                     r_hdr_valid, w_hdr_valid_nxt;
    logic [127:0]             r_hdr;
    logic [12:0]              r_hdr_len_bytes;
    logic                     r_hdr_last, w_hdr_last_nxt;
    logic                     r_err, w_err_nxt;
    logic                     r_is_write, w_is_write_nxt;
    logic [ADDR_WIDTH-1:0]    r_cur_addr, w_cur_addr_nxt, w_nxt_addr;
    logic [REQ_LEN_WIDTH-1:0] r_remaining, w_rem_nxt, w_nxt_rem;
    logic [NUM_TAGS-1:0]      r_tag_busy, w_free_mask, w_alloc_mask;
    logic                     w_tag_found, w_load, w_alloc, w_req_bad;
    logic [TAG_WIDTH-1:0]     w_tag_sel;

    // Header builder inputs and results
    logic [ADDR_WIDTH-1:0]    w_b_addr;
    logic [REQ_LEN_WIDTH-1:0] w_b_rem;
    logic                     w_b_write, w_b_last;
    logic [12:0]              w_b_bound, w_b_cap, w_b_lim, w_b_chunk;
    logic [9:0]               w_b_len_dw, w_b_tag10;
    logic [3:0]               w_b_last_be;
    logic [63:0]              w_b_addr64;
    logic [127:0]             w_b_hdr;

    assign req_ready     = r_req_ready;
    assign hdr_valid     = r_hdr_valid;
    assign hdr           = r_hdr;
    assign hdr_len_bytes = r_hdr_len_bytes;
    assign hdr_last      = r_hdr_last;
    assign err           = r_err;

    assign w_req_bad  = (req_addr[1:0] != 2'b00) || (req_len[1:0] != 2'b00) ||
                        (req_len == '0);
    assign w_nxt_addr = r_cur_addr + ADDR_WIDTH'(r_hdr_len_bytes);
    assign w_nxt_rem  = r_remaining - REQ_LEN_WIDTH'(r_hdr_len_bytes);

    // Lowest free tag in the registered bitmap, plus release/allocate masks
    always_comb begin
        w_tag_found = 1'b0;
        w_tag_sel   = '0;
        w_free_mask = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            w_tag_found    = w_tag_found | ~r_tag_busy[i];
            w_tag_sel      = r_tag_busy[i] ? w_tag_sel : TAG_WIDTH'(i);
            w_free_mask[i] = tag_free_valid && (tag_free == TAG_WIDTH'(i));
        end
        w_alloc_mask = w_alloc ? (NUM_TAGS'(1) << w_tag_sel) : '0;
    end

    // Select where the next header's address/length come from
    always_comb begin
        case (r_state)
            S_IDLE: begin
                w_b_addr  = req_addr;
                w_b_rem   = req_len;
                w_b_write = req_is_write;
            end
            S_EMIT: begin
                w_b_addr  = w_nxt_addr;
                w_b_rem   = w_nxt_rem;
                w_b_write = r_is_write;
            end
            default: begin
                w_b_addr  = r_cur_addr;
                w_b_rem   = r_remaining;
                w_b_write = r_is_write;
            end
        endcase
    end

    // Chunk size and 4DW header image for the selected address/length
    always_comb begin
        w_b_bound   = 13'd4096 - {1'b0, w_b_addr[11:0]};
        w_b_cap     = w_b_write ? LP_MPS : LP_MRRS;
        w_b_lim     = (w_b_cap < w_b_bound) ? w_b_cap : w_b_bound;
        w_b_chunk   = (32'(w_b_rem) < 32'(w_b_lim)) ? 13'(w_b_rem) : w_b_lim;
        w_b_last    = (32'(w_b_rem) == 32'(w_b_chunk));
        w_b_len_dw  = w_b_chunk[11:2];      // 4096 B naturally encodes as 0
        w_b_tag10   = w_b_write ? 10'd0 : 10'(w_tag_sel);
        w_b_last_be = (w_b_chunk > 13'd4) ? 4'hF : 4'h0;
        w_b_addr64  = 64'(w_b_addr) & ~64'd3;
        w_b_hdr             = '0;
        w_b_hdr[7:0]        = {(w_b_write ? 3'b011 : 3'b001), 5'b00000};
        w_b_hdr[15]         = (TAG_WIDTH == 10) ? w_b_tag10[9] : 1'b0;
        w_b_hdr[11]         = (TAG_WIDTH == 10) ? w_b_tag10[8] : 1'b0;
        w_b_hdr[17:16]      = w_b_len_dw[9:8];
        w_b_hdr[31:24]      = w_b_len_dw[7:0];
        w_b_hdr[39:32]      = REQUESTER_ID[15:8];
        w_b_hdr[47:40]      = REQUESTER_ID[7:0];
        w_b_hdr[55:48]      = w_b_tag10[7:0];
        w_b_hdr[63:56]      = {w_b_last_be, 4'hF};
        for (int k = 0; k < 8; k++) begin
            w_b_hdr[64 + 8*k +: 8] = w_b_addr64[63 - 8*k -: 8];
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_load          = 1'b0;
        w_alloc         = 1'b0;
        w_hdr_valid_nxt = r_hdr_valid;
        w_hdr_last_nxt  = r_hdr_last;
        w_err_nxt       = 1'b0;
        w_cur_addr_nxt  = r_cur_addr;
        w_rem_nxt       = r_remaining;
        w_is_write_nxt  = r_is_write;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_req_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_cur_addr_nxt = req_addr;
                        w_rem_nxt      = req_len;
                        w_is_write_nxt = req_is_write;
                        if (req_is_write || w_tag_found) begin
                            w_load      = 1'b1;
                            w_state_nxt = S_EMIT;
                        end else begin
                            w_state_nxt = S_WAIT_TAG;
                        end
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_EMIT: begin
                if (hdr_ready) begin
                    w_cur_addr_nxt = w_nxt_addr;
                    w_rem_nxt      = w_nxt_rem;
                    if (r_hdr_last) begin
                        w_state_nxt     = S_IDLE;
                        w_hdr_valid_nxt = 1'b0;
                        w_hdr_last_nxt  = 1'b0;
                    end else if (r_is_write || w_tag_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt     = S_WAIT_TAG;
                        w_hdr_valid_nxt = 1'b0;
                        w_hdr_last_nxt  = 1'b0;
                    end
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_WAIT_TAG: begin
                if (w_tag_found) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_EMIT;
                end else begin
                    w_state_nxt = S_WAIT_TAG;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_hdr_valid_nxt = 1'b0;
                w_hdr_last_nxt  = 1'b0;
            end
        endcase
        if (w_load) begin
            w_hdr_valid_nxt = 1'b1;
            w_hdr_last_nxt  = w_b_last;
            w_alloc         = ~w_b_write;
        end else begin
            w_alloc = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, request context and tag bitmap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_ready     <= 1'b1;
            r_hdr_valid     <= 1'b0;
            r_hdr           <= '0;
            r_hdr_len_bytes <= 13'd0;
            r_hdr_last      <= 1'b0;
            r_err           <= 1'b0;
            r_is_write      <= 1'b0;
            r_cur_addr      <= '0;
            r_remaining     <= '0;
            r_tag_busy      <= '0;
        end else begin
            r_req_ready     <= (w_state_nxt == S_IDLE);
            r_hdr_valid     <= w_hdr_valid_nxt;
            r_hdr           <= w_load ? w_b_hdr : r_hdr;
            r_hdr_len_bytes <= w_load ? w_b_chunk : r_hdr_len_bytes;
            r_hdr_last      <= w_hdr_last_nxt;
            r_err           <= w_err_nxt;
            r_is_write      <= w_is_write_nxt;
            r_cur_addr      <= w_cur_addr_nxt;
            r_remaining     <= w_rem_nxt;
            r_tag_busy      <= (r_tag_busy & ~w_free_mask) | w_alloc_mask;
        end
    end

endmodule
